// File: rtl/bus_arbiter_2way.sv
// rtl/bus_arbiter_2way.sv - two-master round-robin arbiter with grant watchdog, drives mux way select
module bus_arbiter_2way #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  input  logic slave_done,
  output logic sel,
  output logic gnt1,
  output logic gnt2,
  output logic busy,
  output logic timeout_err
);

  // Watchdog counter only has to reach TIMEOUT-1; width derived, not user-set.
  localparam int CNTW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit WD_EN = (TIMEOUT != 0);
  localparam logic [CNTW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            last_q, last_d;      // way served most recently: 0 = master1, 1 = master2
  logic            terr_q, terr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic own_req;
  logic other_req;
  logic wd_fire;
  logic release_c;

  // Next-state, way select, round-robin pointer and watchdog update
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    terr_d    = 1'b0;
    own_req   = (state_q == OWN2) ? req2 : req1;
    other_req = (state_q == OWN2) ? req1 : req2;
    wd_fire   = 1'b0;
    release_c = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie, master1 wins only if master2 was served last.
        if (req1 && (!req2 || last_q)) begin
          state_d = OWN1;
          sel_d   = 1'b0;
          cnt_d   = '0;
        end else if (req2) begin
          state_d = OWN2;
          sel_d   = 1'b1;
          cnt_d   = '0;
        end
      end

      OWN1, OWN2: begin
        // slave_done suppresses a same-cycle watchdog fire so a normal release wins.
        wd_fire   = WD_EN && (cnt_q == WD_LAST) && !slave_done && own_req;
        release_c = slave_done || !own_req || wd_fire;
        if (release_c) begin
          last_d = (state_q == OWN2);
          terr_d = wd_fire;
          cnt_d  = '0;
          if (other_req) begin
            // Direct handover without an idle gap.
            state_d = (state_q == OWN2) ? OWN1 : OWN2;
            sel_d   = (state_q == OWN1);
          end else begin
            state_d = IDLE;
          end
        end else if (WD_EN && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel         = sel_q;
  assign gnt1        = (state_q == OWN1);
  assign gnt2        = (state_q == OWN2);
  assign busy        = (state_q == OWN1) || (state_q == OWN2);
  assign timeout_err = terr_q;

endmodule
